// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : ID/EX pipeline register with ALU decode, operand forwarding,
//               load-use hazard detection, stall hold and flush bubble.
// Revision    : 1.0
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_alu_src,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_write_reg;
  logic              r_alu_src;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic [2:0]        r_alu_ctrl;

  logic [2:0]        w_alu_dec;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic              w_load_use;
  logic              w_bubble;

  always_comb begin
    w_alu_dec = C_ALU_ADD;
    case (id_alu_op)
      2'b00:   w_alu_dec = C_ALU_ADD;
      2'b01:   w_alu_dec = C_ALU_SUB;
      2'b11:   w_alu_dec = C_ALU_OR;
      default: begin
        case (id_funct)
          6'b100000: w_alu_dec = C_ALU_ADD;
          6'b100010: w_alu_dec = C_ALU_SUB;
          6'b100100: w_alu_dec = C_ALU_AND;
          6'b100101: w_alu_dec = C_ALU_OR;
          6'b101010: w_alu_dec = C_ALU_SLT;
          default:   w_alu_dec = C_ALU_ADD;
        endcase
      end
    endcase
  end

  // EX/MEM has the younger result, so it is checked first; r0 never forwards.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs))
      w_fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs))
      w_fwd_rs = memwb_result;
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt))
      w_fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt))
      w_fwd_rt = memwb_result;
  end

  assign w_load_use = id_valid && r_valid && r_mem_read && (r_rt != '0) &&
                      ((r_rt == id_rs) || (r_rt == id_rt));

  assign w_bubble = flush || (!stall && (w_load_use || !id_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_write_reg  <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_ctrl   <= C_ALU_ADD;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_write_reg  <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_ctrl   <= C_ALU_ADD;
    end else if (stall) begin
      // Absorb results retiring during the stall so they are not lost.
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else begin
      r_valid      <= 1'b1;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_write_reg  <= id_reg_dst ? id_rd : id_rt;
      r_alu_src    <= id_alu_src;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
      r_mem_to_reg <= id_mem_to_reg;
      r_alu_ctrl   <= w_alu_dec;
    end
  end

  assign load_use_stall = w_load_use;
  assign ex_valid       = r_valid;
  assign alu_a          = w_fwd_rs;
  assign alu_b          = r_alu_src ? r_imm : w_fwd_rt;
  assign alu_control    = r_alu_ctrl;
  assign ex_store_data  = w_fwd_rt;
  assign ex_write_reg   = r_write_reg;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_mem_to_reg  = r_mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage : self-checking bench for id_ex_stage against a reference
//                  model of the instruction held in EX.
// Revision       : 1.0
// ============================================================================
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_control;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, wreg;
    logic [31:0] rs_data, rt_data, imm;
    logic        alu_src, rw, mr, mw, m2r;
    logic [2:0]  aluc;
  } ex_t;

  ex_t m;

  function automatic ex_t empty_ex();
    ex_t e;
    e      = '0;
    e.aluc = 3'b010;
    return e;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b001;
    if (f == 6'h20) return 3'b010;
    if (f == 6'h22) return 3'b110;
    if (f == 6'h24) return 3'b000;
    if (f == 6'h25) return 3'b001;
    if (f == 6'h2A) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) return d;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return d;
  endfunction

  function automatic logic ref_load_use();
    return id_valid && m.valid && m.mr && (m.rt != 5'd0) &&
           ((m.rt == id_rs) || (m.rt == id_rt));
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = m;
    if (flush) return empty_ex();
    if (stall) begin
      n.rs_data = ref_fwd(m.rs, m.rs_data);
      n.rt_data = ref_fwd(m.rt, m.rt_data);
      return n;
    end
    if (ref_load_use() || !id_valid) return empty_ex();
    n.valid   = 1'b1;
    n.rs      = id_rs;
    n.rt      = id_rt;
    n.wreg    = id_reg_dst ? id_rd : id_rt;
    n.rs_data = id_rs_data;
    n.rt_data = id_rt_data;
    n.imm     = id_imm;
    n.alu_src = id_alu_src;
    n.rw      = id_reg_write;
    n.mr      = id_mem_read;
    n.mw      = id_mem_write;
    n.m2r     = id_mem_to_reg;
    n.aluc    = ref_alu(id_alu_op, id_funct);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [31:0] st;
    st = ref_fwd(m.rt, m.rt_data);
    chk({ph, ":load_use"}, 32'(load_use_stall), 32'(ref_load_use()));
    chk({ph, ":ex_valid"}, 32'(ex_valid), 32'(m.valid));
    chk({ph, ":alu_a"}, alu_a, ref_fwd(m.rs, m.rs_data));
    chk({ph, ":alu_b"}, alu_b, m.alu_src ? m.imm : st);
    chk({ph, ":store"}, ex_store_data, st);
    chk({ph, ":aluc"}, 32'(alu_control), 32'(m.aluc));
    chk({ph, ":wreg"}, 32'(ex_write_reg), 32'(m.wreg));
    chk({ph, ":ctrl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
        32'({m.rw, m.mr, m.mw, m.m2r}));
  endtask

  task automatic step(input string ph);
    #1;
    check_all(ph);
    m = model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_src = 0; id_alu_op = 0; id_funct = 0;
    id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                           input logic [1:0] op, input logic [5:0] f, input logic [5:0] ctl);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_op = op; id_funct = f;
    {id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = ctl;
  endtask

  task automatic rand_inputs();
    id_valid        = ($urandom_range(0, 3) != 0);
    id_rs           = 5'($urandom_range(0, 7));
    id_rt           = 5'($urandom_range(0, 7));
    id_rd           = 5'($urandom_range(0, 7));
    id_rs_data      = $urandom;
    id_rt_data      = $urandom;
    id_imm          = $urandom;
    id_alu_src      = 1'($urandom);
    id_alu_op       = 2'($urandom);
    id_funct        = ($urandom_range(0, 1) != 0) ? 6'($urandom)
                      : 6'(32 + 2 * $urandom_range(0, 5));
    id_reg_dst      = 1'($urandom);
    id_reg_write    = 1'($urandom);
    id_mem_read     = ($urandom_range(0, 2) == 0);
    id_mem_write    = 1'($urandom);
    id_mem_to_reg   = 1'($urandom);
    stall           = ($urandom_range(0, 4) == 0);
    flush           = ($urandom_range(0, 9) == 0);
    exmem_reg_write = 1'($urandom);
    exmem_rd        = 5'($urandom_range(0, 7));
    exmem_result    = $urandom;
    memwb_reg_write = 1'($urandom);
    memwb_rd        = 5'($urandom_range(0, 7));
    memwb_result    = $urandom;
  endtask

  initial begin
    idle();
    m     = empty_ex();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_aluc", 32'(alu_control), 32'h2);
    chk("reset_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
    #2 rst_n = 1;
    step("reset_idle");

    // R-type add, rd destination
    set_instr(5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'h0, 2'b10, 6'b100000, 6'b011000);
    step("radd_pre");
    chk("radd_a", alu_a, 32'd5);
    chk("radd_b", alu_b, 32'd7);
    chk("radd_aluc", 32'(alu_control), 32'h2);
    chk("radd_wreg", 32'(ex_write_reg), 32'd9);

    // Forwarding priority on rs=3
    set_instr(5'd3, 5'd5, 5'd6, 32'h33, 32'h55, 32'h0, 2'b10, 6'b100010, 6'b011000);
    step("fwd_cap");
    idle();
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1 chk("fwd_exmem", alu_a, 32'h11);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", alu_a, 32'h22);
    exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 chk("fwd_r0", alu_a, 32'h33);
    step("fwd_end");

    // Load-use: lw r4 in EX, consumer of r4 in ID
    idle();
    set_instr(5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 32'h8, 2'b00, 6'd0, 6'b101101);
    step("lw_cap");
    set_instr(5'd4, 5'd5, 5'd7, 32'h1, 32'h2, 32'h0, 2'b10, 6'b100101, 6'b011000);
    #1 chk("lu_flag", 32'(load_use_stall), 32'd1);
    step("lu_edge");
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    step("lu_retry");

    // Stall refresh: store with rt=6, writeback of 0xAB retires mid-stall
    idle();
    set_instr(5'd2, 5'd6, 5'd0, 32'h40, 32'h1, 32'h4, 2'b00, 6'd0, 6'b100010);
    step("st_cap");
    stall = 1;
    set_instr(5'd7, 5'd7, 5'd7, 32'hdead, 32'hbeef, 32'h0, 2'b10, 6'b101010, 6'b011000);
    step("stall1");
    chk("stall1_mw", 32'(ex_mem_write), 32'd1);
    memwb_reg_write = 1; memwb_rd = 5'd6; memwb_result = 32'hAB;
    step("stall2");
    chk("stall2_mw", 32'(ex_mem_write), 32'd1);
    memwb_reg_write = 0;
    step("stall3");
    chk("stall3_valid", 32'(ex_valid), 32'd1);
    stall = 0;
    #1 chk("stall_refresh", ex_store_data, 32'hAB);
    chk("stall_aluc", 32'(alu_control), 32'h2);

    // Flush + stall with sw in EX
    idle();
    set_instr(5'd2, 5'd6, 5'd0, 32'h40, 32'h9, 32'h4, 2'b00, 6'd0, 6'b100010);
    step("sw_cap");
    flush = 1; stall = 1;
    step("flush_stall");
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_mw", 32'(ex_mem_write), 32'd0);
    idle();

    // Asynchronous reset mid-cycle
    set_instr(5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 32'h0, 2'b11, 6'd0, 6'b011000);
    step("ar_cap");
    #2 rst_n = 0;
    #1;
    m = empty_ex();
    chk("async_valid", 32'(ex_valid), 32'd0);
    chk("async_aluc", 32'(alu_control), 32'h2);
    chk("async_rw", 32'(ex_reg_write), 32'd0);
    #1 rst_n = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-select stage for the 5-stage MIPS core. It captures decoded instruction fields from ID and decodes ALUOp/funct into the 3-bit ALU control code. It resolves EX/MEM and MEM/WB forwarding and detects load-use hazards, then presents A, B and control directly to the execution ALU. It also supports downstream stall (hold) and branch/exception flush (bubble).

Parameters:
DATA_W, 32, datapath width of operands, immediate and results
REG_AW, 5, register-file address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DATA_W  register-file read of rs
id_rt_data  in  DATA_W  register-file read of rt
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_AW  register specifiers
id_alu_src  in  1  1: B = immediate
id_alu_op  in  2  00 add, 01 sub, 10 R-type, 11 or
id_funct  in  6  instruction funct field
id_reg_dst  in  1  1: destination = rd, 0: destination = rt
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
stall  in  1  downstream stall; hold the stage
flush  in  1  kill the instruction in EX
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
load_use_stall  out  1  combinational; ID/IF must hold this cycle
ex_valid  out  1  EX holds a real instruction
alu_a, alu_b  out  DATA_W  ALU operands (combinational from registers and forwarding)
alu_control  out  3  ALU code: 010 add, 110 sub, 000 and, 001 or, 111 slt
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_write_reg  out  REG_AW  destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control bits

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers clear to 0 except alu_control, which resets to 010.
  - ex_valid=0; all ex_* control bits 0.
  - alu_a/alu_b show forwarded or zero data only.
- Hazard detection (combinational):
  - load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
- Update priority per rising edge:
  - flush: load bubble.
  - else stall: hold.
  - else load_use_stall: load bubble.
  - else capture ID.
  - Bubble: ex_valid=0, all control bits 0, alu_control=010, data fields don't-care (cleared to 0).
- Capture:
  - ex_valid<=id_valid. Register rs/rt data, imm, rs, rt, alu_src and control bits.
  - ex_write_reg <= id_reg_dst ? id_rd : id_rt.
  - When id_valid=0, the stage captures a bubble.
- ALU decode (registered at capture):
  - alu_op 00 -> 010; 01 -> 110; 11 -> 001.
  - alu_op 10 uses funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
- Forwarding, per operand X in {rs, rt}:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_X, use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_X, use memwb_result.
  - Else use the registered data. EX/MEM wins when both match.
  - Register 0 is never forwarded.
- Operand outputs:
  - alu_a = fwd(rs).
  - ex_store_data = fwd(rt).
  - alu_b = alu_src ? imm : fwd(rt).
- Stall hold:
  - Control, specifiers and imm are held.
  - Registered rs/rt data are overwritten each stalled cycle with fwd(rs)/fwd(rt), so a writeback that retires during the stall is not lost.
- Simultaneous flush+stall: flush wins and a bubble is loaded.
- flush or reset mid-stall leaves no residual state.
- Latency: ID inputs appear on outputs 1 cycle after capture. Forwarding adds 0 cycles.

Test Plan:
- Reset release, no stimulus -> ex_valid=0, alu_control=010, all ex_* control bits 0.
- Capture R-type add: rs_data=5, rt_data=7, alu_op=10, funct=100000, reg_dst=1, rd=9 -> next cycle alu_a=5, alu_b=7, alu_control=010, ex_write_reg=9.
- Forwarding priority: EX holds rs=3; exmem_rd=3 with result 0x11; memwb_rd=3 with result 0x22 (both write enables 1) -> alu_a=0x11. Drop exmem_reg_write -> alu_a=0x22. Set exmem_rd=0 -> no forwarding.
- Load-use: EX holds lw (mem_read=1, rt=4); ID presents rs=4, id_valid=1 -> load_use_stall=1; next edge ex_valid=0, ex_reg_write=0.
- Stall refresh: stall=1 for 3 cycles; memwb writes 0xAB to EX's rt in cycle 2 -> after stall release ex_store_data=0xAB; control bits unchanged throughout the stall.
- flush and stall asserted together with valid sw in EX -> next cycle ex_valid=0, ex_mem_write=0. Additionally, asynchronous rst_n pulse mid-cycle clears the stage immediately.
